// File: rtl/upper_unpack.sv
`default_nettype none
// ============================================================================
// Module   : upper_unpack
// Purpose  : Serialises one BEATS*WIDTH-bit word, taken over a valid/ready
//            handshake, into BEATS WIDTH-bit beats on a second valid/ready
//            port, flagging the final beat with out_last.
//            Build option UPPER_UNPACK_MSB_FIRST_EN sends the most
//            significant slice first; LSB-first when it is not defined.
// Revision : 1.0 - initial release
// ============================================================================
module upper_unpack #(
    parameter  int WIDTH = 10,
    parameter  int BEATS = 4,
    localparam int IN_W  = WIDTH * BEATS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    // Counter is at least one bit wide so BEATS==1 still elaborates cleanly.
    localparam int                 C_CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST    = C_CNT_W'(BEATS - 1);
    localparam logic [C_CNT_W-1:0] C_ONE     = C_CNT_W'(1);
    localparam logic [0:0]         C_ST_IDLE = 1'b0;
    localparam logic [0:0]         C_ST_SEND = 1'b1;

    logic [0:0]         r_state;
    logic [IN_W-1:0]    r_shift;
    logic [C_CNT_W-1:0] r_count;

    logic w_xfer;
    logic w_done;
    logic w_accept;

    // Handshake decode; in_ready depends on out_ready only, never on in_valid.
    always_comb begin
        out_valid = (r_state == C_ST_SEND);
        busy      = (r_state == C_ST_SEND);
        out_last  = (r_state == C_ST_SEND) && (r_count == C_LAST);
        w_xfer    = out_valid & out_ready;
        w_done    = w_xfer & out_last;
        in_ready  = (r_state == C_ST_IDLE) | w_done;
        w_accept  = in_valid & in_ready;
    end

    // Current beat always sits at the outgoing end of the shift register.
`ifdef UPPER_UNPACK_MSB_FIRST_EN
    assign out_data = r_shift[IN_W-1 -: WIDTH];
`else
    assign out_data = r_shift[WIDTH-1:0];
`endif

    // Word load, beat advance and end-of-word handling; an accept on the
    // last-beat cycle reloads directly so consecutive words have no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= C_ST_IDLE;
            r_shift <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_state <= C_ST_SEND;
            r_shift <= in_data;
            r_count <= '0;
        end else if (w_done) begin
            r_state <= C_ST_IDLE;
            r_count <= '0;
        end else if (w_xfer) begin
`ifdef UPPER_UNPACK_MSB_FIRST_EN
            r_shift <= r_shift << WIDTH;
`else
            r_shift <= r_shift >> WIDTH;
`endif
            r_count <= r_count + C_ONE;
        end
    end

endmodule
`default_nettype wire
